// File: rtl/uart_cmd_pkg.sv
// rtl/uart_cmd_pkg.sv - shared types and constants for the UART command sequencer
// Contents: handshake FSM state encoding, opcode constants, frame length,
// and the frame checksum helper.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        HS_IDLE,
        HS_ARM,
        HS_WAIT,
        HS_CAPT,
        HS_REL
    } hs_state_t;

    localparam logic [7:0] CMD_WR   = 8'h01;
    localparam logic [7:0] CMD_RUN  = 8'h02;
    localparam logic [7:0] CMD_STOP = 8'h03;

    localparam int         FRAME_LEN = 6;
    localparam logic [2:0] LAST_IDX  = 3'(FRAME_LEN - 1);

    function automatic logic [7:0] frame_chk(input logic [7:0] cmd,
                                             input logic [7:0] addr,
                                             input logic [7:0] dh,
                                             input logic [7:0] dl);
        return cmd ^ addr ^ dh ^ dl;
    endfunction

endpackage

// File: rtl/uart_byte_hs.sv
// rtl/uart_byte_hs.sv - ready/valid handshake FSM toward the UART byte receiver
// Ports:
//   clk, ap_rstn      clock, asynchronous active-low reset
//   rx_valid, rx_data receiver byte valid (level) and data
//   rx_ready          registered ready toward the receiver
//   capt              combinational: byte accepted this cycle (WAIT and rx_valid)
//   byte_stb          one-cycle strobe during REL; byte_data is stable then
//   byte_data         last captured byte
module uart_byte_hs
    import uart_cmd_pkg::*;
(
    input  logic       clk,
    input  logic       ap_rstn,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       rx_ready,
    output logic       capt,
    output logic       byte_stb,
    output logic [7:0] byte_data
);

    hs_state_t  state_q, state_d;
    logic       rx_ready_q, rx_ready_d;
    logic       byte_stb_q, byte_stb_d;
    logic [7:0] byte_data_q, byte_data_d;

    always_comb begin
        state_d     = state_q;
        byte_data_d = byte_data_q;
        capt        = 1'b0;
        case (state_q)
            HS_IDLE: state_d = HS_ARM;
            // A valid still high from the previous byte must drop before we
            // look for a new one, otherwise the same byte is taken twice.
            HS_ARM:  if (!rx_valid) state_d = HS_WAIT;
            HS_WAIT: begin
                if (rx_valid) begin
                    capt    = 1'b1;
                    state_d = HS_CAPT;
                end
            end
            HS_CAPT: begin
                byte_data_d = rx_data;
                state_d     = HS_REL;
            end
            HS_REL:  state_d = HS_ARM;
            default: state_d = HS_IDLE;
        endcase
        // Outputs are decoded from the next state so they line up with state_q.
        rx_ready_d = (state_d == HS_ARM) || (state_d == HS_WAIT);
        byte_stb_d = (state_d == HS_REL);
    end

    always_ff @(posedge clk or negedge ap_rstn) begin
        if (!ap_rstn) begin
            state_q     <= HS_IDLE;
            rx_ready_q  <= 1'b0;
            byte_stb_q  <= 1'b0;
            byte_data_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            rx_ready_q  <= rx_ready_d;
            byte_stb_q  <= byte_stb_d;
            byte_data_q <= byte_data_d;
        end
    end

    assign rx_ready  = rx_ready_q;
    assign byte_stb  = byte_stb_q;
    assign byte_data = byte_data_q;

endmodule

// File: rtl/uart_cmd_sequencer.sv
// rtl/uart_cmd_sequencer.sv - assembles 6-byte UART command frames into config writes and run control
// Ports:
//   clk, ap_rstn         clock, asynchronous active-low reset
//   rx_ready/valid/data  handshake with the UART byte receiver
//   cfg_we/addr/wdata    config register write (strobe, held address/data)
//   run_en               sampling engine enable level
//   frame_ok/frame_err   one-cycle frame result pulses
//   err_cnt              saturating count of rejected frames
module uart_cmd_sequencer
    import uart_cmd_pkg::*;
#(
    parameter logic [7:0] HDR         = 8'hA5,
    parameter int         TIMEOUT_CYC = 1_000_000,
    parameter int         TW          = 20
) (
    input  logic        clk,
    input  logic        ap_rstn,
    output logic        rx_ready,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        cfg_we,
    output logic [7:0]  cfg_addr,
    output logic [15:0] cfg_wdata,
    output logic        run_en,
    output logic        frame_ok,
    output logic        frame_err,
    output logic [7:0]  err_cnt
);

    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    logic       hs_capt, byte_stb;
    logic [7:0] byte_data;

    uart_byte_hs u_hs (
        .clk       (clk),
        .ap_rstn   (ap_rstn),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .capt      (hs_capt),
        .byte_stb  (byte_stb),
        .byte_data (byte_data)
    );

    logic [2:0]    idx_q, idx_d;
    logic [7:0]    cmd_q, cmd_d, addr_q, addr_d, dh_q, dh_d, dl_q, dl_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          cfg_we_q, cfg_we_d, run_en_q, run_en_d;
    logic          frame_ok_q, frame_ok_d, frame_err_q, frame_err_d;
    logic [7:0]    cfg_addr_q, cfg_addr_d, err_cnt_q, err_cnt_d;
    logic [15:0]   cfg_wdata_q, cfg_wdata_d;
    logic          bad;

    always_comb begin
        idx_d       = idx_q;
        cmd_d       = cmd_q;
        addr_d      = addr_q;
        dh_d        = dh_q;
        dl_d        = dl_q;
        tmo_d       = tmo_q;
        cfg_we_d    = 1'b0;
        cfg_addr_d  = cfg_addr_q;
        cfg_wdata_d = cfg_wdata_q;
        run_en_d    = run_en_q;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        bad         = 1'b0;

        if (byte_stb) begin
            if (idx_q == 3'd0) begin
                // Hunting: anything but the header is dropped without an error.
                if (byte_data == HDR) idx_d = 3'd1;
            end else if (idx_q == LAST_IDX) begin
                idx_d = 3'd0;
                if (frame_chk(cmd_q, addr_q, dh_q, dl_q) != byte_data) begin
                    bad = 1'b1;
                end else begin
                    case (cmd_q)
                        CMD_WR: begin
                            cfg_we_d    = 1'b1;
                            cfg_addr_d  = addr_q;
                            cfg_wdata_d = {dh_q, dl_q};
                        end
                        CMD_RUN:  run_en_d = 1'b1;
                        CMD_STOP: run_en_d = 1'b0;
                        default:  bad = 1'b1;
                    endcase
                end
                frame_ok_d  = !bad;
                frame_err_d = bad;
            end else begin
                case (idx_q)
                    3'd1:    cmd_d  = byte_data;
                    3'd2:    addr_d = byte_data;
                    3'd3:    dh_d   = byte_data;
                    default: dl_d   = byte_data;
                endcase
                idx_d = idx_q + 3'd1;
            end
        end

        // Inter-byte timeout. A capture in the expiry cycle wins, so the
        // clear is checked first. byte_stb (REL) and rx_ready (ARM/WAIT)
        // are never high together, so idx_d is not contended.
        if (hs_capt) begin
            tmo_d = '0;
        end else if (idx_q != 3'd0 && rx_ready) begin
            if (tmo_q == TMO_LAST) begin
                tmo_d       = '0;
                idx_d       = 3'd0;
                frame_err_d = 1'b1;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end

        if (frame_err_d && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge ap_rstn) begin
        if (!ap_rstn) begin
            idx_q       <= 3'd0;
            cmd_q       <= 8'h00;
            addr_q      <= 8'h00;
            dh_q        <= 8'h00;
            dl_q        <= 8'h00;
            tmo_q       <= '0;
            cfg_we_q    <= 1'b0;
            cfg_addr_q  <= 8'h00;
            cfg_wdata_q <= 16'h0000;
            run_en_q    <= 1'b0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_cnt_q   <= 8'h00;
        end else begin
            idx_q       <= idx_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            dh_q        <= dh_d;
            dl_q        <= dl_d;
            tmo_q       <= tmo_d;
            cfg_we_q    <= cfg_we_d;
            cfg_addr_q  <= cfg_addr_d;
            cfg_wdata_q <= cfg_wdata_d;
            run_en_q    <= run_en_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign cfg_we    = cfg_we_q;
    assign cfg_addr  = cfg_addr_q;
    assign cfg_wdata = cfg_wdata_q;
    assign run_en    = run_en_q;
    assign frame_ok  = frame_ok_q;
    assign frame_err = frame_err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// tb/tb_uart_cmd_sequencer.sv - self-checking bench for uart_cmd_sequencer
module tb_uart_cmd_sequencer;

    localparam int TMO = 100;

    logic        clk, ap_rstn, rx_ready, rx_valid;
    logic [7:0]  rx_data, cfg_addr, err_cnt;
    logic        cfg_we, run_en, frame_ok, frame_err;
    logic [15:0] cfg_wdata;

    uart_cmd_sequencer #(.HDR(8'hA5), .TIMEOUT_CYC(TMO), .TW(20)) dut (
        .clk       (clk),
        .ap_rstn   (ap_rstn),
        .rx_ready  (rx_ready),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .run_en    (run_en),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_ok = 0, n_err = 0, n_we = 0, n_both = 0;

    always @(negedge clk) begin
        if (frame_ok)              n_ok++;
        if (frame_err)             n_err++;
        if (cfg_we)                n_we++;
        if (frame_ok && frame_err) n_both++;
    end

    typedef struct {
        logic [63:0] bytes;   // first byte in [63:56]
        int          n;
        int          hold;    // cycles rx_valid stays high after capture
        int          d_ok, d_err, d_we;
        logic        run;
        logic [7:0]  cnt;
        logic [7:0]  addr;
        logic [15:0] wdata;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [63:0] bytes, input int n, input int hold,
                           input int dok, input int derr, input int dwe, input logic run,
                           input logic [7:0] cnt, input logic [7:0] addr, input logic [15:0] wd);
        vec_t v;
        v.bytes = bytes; v.n = n; v.hold = hold;
        v.d_ok = dok; v.d_err = derr; v.d_we = dwe;
        v.run = run; v.cnt = cnt; v.addr = addr; v.wdata = wd;
        vq.push_back(v);
    endtask

    task automatic wait_ready_high();
        int n = 0;
        while (!rx_ready && n < 1000) begin @(negedge clk); n++; end
        if (n >= 1000) begin checks++; errors++; $display("FAIL ready_high_wait act=0 exp=1"); end
    endtask

    task automatic wait_ready_low();
        int n = 0;
        while (rx_ready && n < 1000) begin @(negedge clk); n++; end
        if (n >= 1000) begin checks++; errors++; $display("FAIL ready_low_wait act=1 exp=0"); end
    endtask

    // Drive only once the sequencer has had a cycle with rx_valid low in ARM,
    // i.e. it is in WAIT.
    task automatic send_byte(input logic [7:0] b, input int hold);
        wait_ready_high();
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        wait_ready_low();
        repeat (hold) @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [63:0] bytes, input int n, input int hold);
        logic [63:0] bb;
        bb = bytes;
        for (int i = 0; i < n; i++) send_byte(bb[63-8*i -: 8], hold);
        repeat (5) @(negedge clk);
    endtask

    initial begin
        int ok0, err0, we0, waited;
        logic [2:0] rp, op, sp;

        ap_rstn  = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;

        // checksum of 01 10 12 34 is 37; of 01 20 AB CD is 47; of 01 A5 00 01 is A5
        add_vec(64'hA5011012_34370000, 6, 0, 1, 0, 1, 1'b0, 8'h00, 8'h10, 16'h1234);
        add_vec(64'hA5020000_00020000, 6, 2, 1, 0, 0, 1'b1, 8'h00, 8'h10, 16'h1234);
        add_vec(64'hA5030000_00030000, 6, 0, 1, 0, 0, 1'b0, 8'h00, 8'h10, 16'h1234);
        add_vec(64'hA5011012_34000000, 6, 1, 0, 1, 0, 1'b0, 8'h01, 8'h10, 16'h1234);
        add_vec(64'hA5070000_00070000, 6, 0, 0, 1, 0, 1'b0, 8'h02, 8'h10, 16'h1234);
        add_vec(64'h00FFA501_20ABCD47, 8, 0, 1, 0, 1, 1'b0, 8'h02, 8'h20, 16'hABCD);
        add_vec(64'hA501A500_01A50000, 6, 3, 1, 0, 1, 1'b0, 8'h02, 8'hA5, 16'h0001);

        repeat (2) @(negedge clk);
        chk("reset_outputs", {15'd0, rx_ready, cfg_we, cfg_addr, run_en, frame_ok, frame_err},
            32'd0);
        chk("reset_wdata_cnt", {8'd0, cfg_wdata, err_cnt}, 32'd0);
        ap_rstn = 1'b1;
        repeat (2) @(negedge clk);
        chk("ready_after_reset", rx_ready, 1);

        foreach (vq[k]) begin
            ok0 = n_ok; err0 = n_err; we0 = n_we;
            send_frame(vq[k].bytes, vq[k].n, vq[k].hold);
            chk($sformatf("v%0d_ok", k),    n_ok - ok0,   vq[k].d_ok);
            chk($sformatf("v%0d_err", k),   n_err - err0, vq[k].d_err);
            chk($sformatf("v%0d_we", k),    n_we - we0,   vq[k].d_we);
            chk($sformatf("v%0d_run", k),   run_en,       vq[k].run);
            chk($sformatf("v%0d_cnt", k),   err_cnt,      vq[k].cnt);
            chk($sformatf("v%0d_addr", k),  cfg_addr,     vq[k].addr);
            chk($sformatf("v%0d_wdata", k), cfg_wdata,    vq[k].wdata);
        end

        // Inter-byte timeout after A5 01.
        err0 = n_err;
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        waited = 0;
        while (n_err == err0 && waited < 300) begin @(negedge clk); waited++; end
        chk("tmo_fired", n_err - err0, 1);
        chk("tmo_window", (waited >= 90 && waited <= 110), 1);
        chk("tmo_cnt", err_cnt, 8'h03);
        ok0 = n_ok; err0 = n_err;
        send_frame(64'hA5020000_00020000, 6, 0);
        chk("after_tmo_ok", n_ok - ok0, 1);
        chk("after_tmo_run", run_en, 1);

        // Capture lands in the very cycle the timeout would expire.
        ok0 = n_ok; err0 = n_err;
        send_byte(8'hA5, 0);
        wait_ready_high();
        repeat (TMO - 1) @(negedge clk);
        rx_data = 8'h01; rx_valid = 1'b1;
        wait_ready_low();
        rx_valid = 1'b0;
        send_frame(64'h10123437_00000000, 4, 0);
        chk("tie_ok", n_ok - ok0, 1);
        chk("tie_err", n_err - err0, 0);

        // Latency, ready-low window and stale valid on the CHK byte.
        send_byte(8'hA5, 0); send_byte(8'h03, 0); send_byte(8'h00, 0);
        send_byte(8'h00, 0); send_byte(8'h00, 0);
        wait_ready_high();
        @(negedge clk);
        rx_data = 8'h03; rx_valid = 1'b1;
        for (int i = 2; i >= 0; i--) begin
            @(negedge clk);
            rp[i] = rx_ready;
            op[i] = frame_ok;
        end
        for (int i = 2; i >= 0; i--) begin
            @(negedge clk);
            sp[i] = rx_ready;
        end
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("hs_ready_pattern", rp, 3'b001);
        chk("latency_ok_pattern", op, 3'b001);
        chk("stale_no_recapture", sp, 3'b111);
        chk("stop_run", run_en, 0);

        // Reset in the middle of a frame.
        send_frame(64'hA5020000_00020000, 6, 0);
        chk("pre_reset_run", run_en, 1);
        send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h10, 0);
        @(negedge clk);
        #2 ap_rstn = 1'b0;
        #1;
        chk("midreset_outputs", {15'd0, rx_ready, cfg_we, cfg_addr, run_en, frame_ok, frame_err},
            32'd0);
        chk("midreset_wdata_cnt", {8'd0, cfg_wdata, err_cnt}, 32'd0);
        repeat (2) @(negedge clk);
        ap_rstn = 1'b1;
        ok0 = n_ok;
        send_frame(64'hA5011012_34370000, 6, 0);
        chk("post_reset_ok", n_ok - ok0, 1);
        chk("post_reset_addr", cfg_addr, 8'h10);
        chk("post_reset_wdata", cfg_wdata, 16'h1234);

        // Saturation of err_cnt.
        for (int i = 0; i < 254; i++) send_frame(64'hA5070000_00070000, 6, 0);
        chk("cnt_254", err_cnt, 8'hFE);
        for (int i = 0; i < 2; i++) send_frame(64'hA5070000_00070000, 6, 0);
        chk("cnt_saturated", err_cnt, 8'hFF);

        chk("ok_err_exclusive", n_both, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
